// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   Forwarding and load-use hazard control for the 5-stage LEGv8 pipeline.
//   Keeps a shadow copy of the register-index/control state held in ID/EX,
//   EX/MEM and MEM/WB, drives the EX-stage operand mux selects, and detects
//   load-use hazards in ID (stall PC and IF/ID, bubble ID/EX).
//
// Ports
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   id_rn / id_rm      source register indices of the instruction in ID
//   id_uses_rn/_rm     ID instruction actually reads rn / rm
//   id_rd              destination register of the instruction in ID
//   id_reg_write       ID instruction writes the register file
//   id_mem_read        ID instruction is a load
//   flush              squash the instruction in ID (taken branch)
//   forward_a/_b       EX operand mux selects: 00 regfile, 01 MEM/WB, 10 EX/MEM
//   stall              load-use hazard this cycle
//   pc_write           PC enable
//   ifid_write         IF/ID enable
//   idex_bubble        load a bubble into ID/EX on this edge
module fwd_hazard_unit #(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             stall,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble
);

  localparam logic [REG_W-1:0] XZR = REG_W'(ZERO_REG);

  typedef struct packed {
    logic [REG_W-1:0] rn;
    logic [REG_W-1:0] rm;
    logic             uses_rn;
    logic             uses_rm;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
  } idex_t;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             reg_write;
  } wb_t;

  localparam idex_t IDEX_BUBBLE = '{
    rn:        XZR,
    rm:        XZR,
    uses_rn:   1'b0,
    uses_rm:   1'b0,
    rd:        XZR,
    reg_write: 1'b0,
    mem_read:  1'b0
  };

  localparam wb_t WB_BUBBLE = '{rd: XZR, reg_write: 1'b0};

  idex_t idex_q, idex_d;
  wb_t   exmem_q, exmem_d;
  wb_t   memwb_q;

  logic exmem_hit_a, exmem_hit_b;
  logic memwb_hit_a, memwb_hit_b;
  logic exmem_valid, memwb_valid;
  logic load_use;

  always_comb begin
    idex_d = idex_bubble ? IDEX_BUBBLE : '{
      rn:        id_rn,
      rm:        id_rm,
      uses_rn:   id_uses_rn,
      uses_rm:   id_uses_rm,
      rd:        id_rd,
      reg_write: id_reg_write,
      mem_read:  id_mem_read
    };
    exmem_d = '{rd: idex_q.rd, reg_write: idex_q.reg_write};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q  <= IDEX_BUBBLE;
      exmem_q <= WB_BUBBLE;
      memwb_q <= WB_BUBBLE;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= exmem_q;
    end
  end

  // A producer only counts if it writes a real register; XZR writes are discarded.
  always_comb begin
    exmem_valid = exmem_q.reg_write && (exmem_q.rd != XZR);
    memwb_valid = memwb_q.reg_write && (memwb_q.rd != XZR);

    exmem_hit_a = idex_q.uses_rn && exmem_valid && (exmem_q.rd == idex_q.rn);
    exmem_hit_b = idex_q.uses_rm && exmem_valid && (exmem_q.rd == idex_q.rm);
    memwb_hit_a = idex_q.uses_rn && memwb_valid && (memwb_q.rd == idex_q.rn);
    memwb_hit_b = idex_q.uses_rm && memwb_valid && (memwb_q.rd == idex_q.rm);

    // EX/MEM checked first: the youngest producer wins.
    forward_a = 2'b00;
    if (exmem_hit_a)      forward_a = 2'b10;
    else if (memwb_hit_a) forward_a = 2'b01;

    forward_b = 2'b00;
    if (exmem_hit_b)      forward_b = 2'b10;
    else if (memwb_hit_b) forward_b = 2'b01;
  end

  // Flush overrides the stall: the dependent instruction is being squashed anyway.
  always_comb begin
    load_use = idex_q.mem_read && (idex_q.rd != XZR) &&
               ((id_uses_rn && (id_rn == idex_q.rd)) ||
                (id_uses_rm && (id_rm == idex_q.rd)));
    stall       = !flush && load_use;
    pc_write    = !stall;
    ifid_write  = !stall;
    idex_bubble = stall || flush;
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

  typedef struct {
    logic [4:0] rn;
    logic [4:0] rm;
    logic [4:0] rd;
    logic       urn;
    logic       urm;
    logic       rw;
    logic       mr;
  } ins_t;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rn, id_rm, id_rd;
  logic       id_uses_rn, id_uses_rm, id_reg_write, id_mem_read, flush;
  logic [1:0] forward_a, forward_b;
  logic       stall, pc_write, ifid_write, idex_bubble;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Instructions that entered the back half of the pipe, oldest first:
  // [0] is in MEM/WB, [1] in EX/MEM, [2] in ID/EX (EX stage).
  ins_t hist[$];

  fwd_hazard_unit #(.REG_W(5), .ZERO_REG(31)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rn        (id_rn),
    .id_rm        (id_rm),
    .id_uses_rn   (id_uses_rn),
    .id_uses_rm   (id_uses_rm),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .forward_a    (forward_a),
    .forward_b    (forward_b),
    .stall        (stall),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .idex_bubble  (idex_bubble)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ins_t bubble();
    ins_t b;
    b.rn = 5'd31; b.rm = 5'd31; b.rd = 5'd31;
    b.urn = 1'b0; b.urm = 1'b0; b.rw = 1'b0; b.mr = 1'b0;
    return b;
  endfunction

  function automatic ins_t cur_id();
    ins_t c;
    c.rn = id_rn; c.rm = id_rm; c.rd = id_rd;
    c.urn = id_uses_rn; c.urm = id_uses_rm; c.rw = id_reg_write; c.mr = id_mem_read;
    return c;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 3; i++) hist.push_back(bubble());
  endtask

  // Select for the EX consumer: nearest older writer of that register, by distance.
  function automatic logic [1:0] exp_fwd(input bit use_rm);
    ins_t ex;
    logic [4:0] src;
    ex  = hist[2];
    src = use_rm ? ex.rm : ex.rn;
    if (!(use_rm ? ex.urm : ex.urn)) return 2'b00;
    for (int d = 1; d <= 2; d++) begin
      if (hist[2-d].rw && hist[2-d].rd != 5'd31 && hist[2-d].rd == src)
        return (d == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  function automatic logic exp_stall();
    ins_t ex;
    ex = hist[2];
    if (flush || !ex.mr || ex.rd == 5'd31) return 1'b0;
    return (id_uses_rn && id_rn == ex.rd) || (id_uses_rm && id_rm == ex.rd);
  endfunction

  task automatic model_step();
    logic bub;
    if (!rst_n) begin
      model_reset();
    end else begin
      bub = flush || exp_stall();
      hist.push_back(bub ? bubble() : cur_id());
      void'(hist.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_id(input logic [4:0] rn, input logic [4:0] rm,
                        input logic urn, input logic urm,
                        input logic [4:0] rd, input logic rw, input logic mr);
    id_rn = rn; id_rm = rm; id_uses_rn = urn; id_uses_rm = urm;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic nop();
    set_id(5'd31, 5'd31, 1'b0, 1'b0, 5'd31, 1'b0, 1'b0);
  endtask

  task automatic drain();
    nop();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_reset();
    logic [7:0] got;
    rst_n = 1'b0;
    set_id(5'($urandom), 5'($urandom), 1'b1, 1'b1, 5'($urandom), 1'b1, 1'b1);
    flush = 1'b0;
    model_reset();
    #1;
    got = {forward_a, forward_b, stall, pc_write, ifid_write, idex_bubble};
    checks++;
    if (got !== 8'b0000_0110) begin
      errors++;
      $display("FAIL reset_during: got %b want %b", got, 8'b0000_0110);
    end
    @(negedge clk);
    rst_n = 1'b1;
    nop();
    for (int i = 0; i < 3; i++) begin
      #1;
      got = {forward_a, forward_b, stall, pc_write, ifid_write, idex_bubble};
      checks++;
      if (got !== 8'b0000_0110) begin
        errors++;
        $display("FAIL reset_idle%0d: got %b want %b", i, got, 8'b0000_0110);
      end
      tick();
    end
  endtask

  task automatic test_alu_distance();
    // distance 1
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0); tick();
    set_id(5'd1, 5'd7, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0); tick();
    nop(); #1;
    checks++;
    if (forward_a !== 2'b10) begin
      errors++;
      $display("FAIL alu_dist1: forward_a %b want 10", forward_a);
    end
    drain();
    // distance 2
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0); tick();
    nop(); tick();
    set_id(5'd1, 5'd7, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0); tick();
    nop(); #1;
    checks++;
    if (forward_a !== 2'b01) begin
      errors++;
      $display("FAIL alu_dist2: forward_a %b want 01", forward_a);
    end
    drain();
    // distance 3: regfile
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0); tick();
    nop(); tick(); tick();
    set_id(5'd1, 5'd7, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0); tick();
    nop(); #1;
    checks++;
    if (forward_a !== 2'b00) begin
      errors++;
      $display("FAIL alu_dist3: forward_a %b want 00", forward_a);
    end
    drain();
  endtask

  task automatic test_double_producer();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0); tick();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0); tick();
    set_id(5'd2, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0); tick();
    nop(); #1;
    checks++;
    if ({forward_a, forward_b} !== 4'b1010) begin
      errors++;
      $display("FAIL double_producer: fa/fb %b want 1010", {forward_a, forward_b});
    end
    drain();
  endtask

  task automatic test_xzr();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd31, 1'b1, 1'b0); tick();
    set_id(5'd31, 5'd31, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0); tick();
    nop(); #1;
    checks++;
    if ({forward_a, forward_b} !== 4'b0000) begin
      errors++;
      $display("FAIL xzr_fwd: fa/fb %b want 0000", {forward_a, forward_b});
    end
    drain();
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd31, 1'b1, 1'b1); tick();
    set_id(5'd31, 5'd31, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0); #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL xzr_load_use: stall %b want 0", stall);
    end
    drain();
  endtask

  task automatic test_load_use();
    logic [3:0] ctl;
    set_id(5'd5, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1); tick();
    set_id(5'd8, 5'd3, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0); #1;
    ctl = {stall, pc_write, ifid_write, idex_bubble};
    checks++;
    if (ctl !== 4'b1001) begin
      errors++;
      $display("FAIL load_use_stall: ctl %b want 1001", ctl);
    end
    tick();
    #1;
    ctl = {stall, pc_write, ifid_write, idex_bubble};
    checks++;
    if (ctl !== 4'b0110) begin
      errors++;
      $display("FAIL load_use_release: ctl %b want 0110", ctl);
    end
    tick();
    nop(); #1;
    checks++;
    if (forward_b !== 2'b01) begin
      errors++;
      $display("FAIL load_use_fwd: forward_b %b want 01", forward_b);
    end
    drain();
  endtask

  task automatic test_flush_priority();
    logic [3:0] ctl;
    set_id(5'd5, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1); tick();
    set_id(5'd8, 5'd3, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0);
    flush = 1'b1; #1;
    ctl = {stall, pc_write, ifid_write, idex_bubble};
    checks++;
    if (ctl !== 4'b0111) begin
      errors++;
      $display("FAIL flush_ctl: ctl %b want 0111", ctl);
    end
    tick();
    flush = 1'b0; nop(); #1;
    checks++;
    if ({forward_a, forward_b, stall} !== 5'b00000) begin
      errors++;
      $display("FAIL flush_bubble: fa/fb/stall %b want 00000", {forward_a, forward_b, stall});
    end
    drain();
  endtask

  task automatic test_async_reset();
    logic [7:0] got;
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1); tick();
    set_id(5'd9, 5'd9, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0); #1;
    // load in ID/EX, consumer in ID: stall is live before reset
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL async_pre: stall %b want 1", stall);
    end
    rst_n = 1'b0; #1;
    got = {forward_a, forward_b, stall, pc_write, ifid_write, idex_bubble};
    checks++;
    if (got !== 8'b0000_0110) begin
      errors++;
      $display("FAIL async_reset: got %b want %b", got, 8'b0000_0110);
    end
    tick();
    rst_n = 1'b1;
    drain();
  endtask

  task automatic test_random();
    logic [4:0] regs [5];
    logic [3:0] ctl, ectl;
    logic [1:0] efa, efb;
    logic es;
    regs[0] = 5'd1; regs[1] = 5'd2; regs[2] = 5'd3; regs[3] = 5'd4; regs[4] = 5'd31;
    for (int n = 0; n < 400; n++) begin
      if (n == 0 || !exp_stall()) begin
        set_id(regs[$urandom_range(0, 4)], regs[$urandom_range(0, 4)],
               1'($urandom), 1'($urandom), regs[$urandom_range(0, 4)],
               1'($urandom), ($urandom_range(0, 2) == 0));
      end
      flush = ($urandom_range(0, 9) == 0);
      #1;
      efa  = exp_fwd(1'b0);
      efb  = exp_fwd(1'b1);
      es   = exp_stall();
      ectl = {es, !es, !es, es || flush};
      ctl  = {stall, pc_write, ifid_write, idex_bubble};
      checks++;
      if (forward_a !== efa) begin
        errors++;
        $display("FAIL rand_fa[%0d]: got %b want %b", n, forward_a, efa);
      end
      checks++;
      if (forward_b !== efb) begin
        errors++;
        $display("FAIL rand_fb[%0d]: got %b want %b", n, forward_b, efb);
      end
      checks++;
      if (ctl !== ectl) begin
        errors++;
        $display("FAIL rand_ctl[%0d]: got %b want %b", n, ctl, ectl);
      end
      tick();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_alu_distance();
    test_double_producer();
    test_xzr();
    test_load_use();
    test_flush_priority();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Pipeline-hazard control block for the 5-stage LEGv8 datapath. It keeps its own shadow copy of the destination-register and control state in ID/EX, EX/MEM and MEM/WB, and drives the 2-bit select codes consumed by the EX-stage 3:1 operand muxes. It also detects load-use hazards in ID and issues stall/bubble controls to the PC, IF/ID and ID/EX registers.

## Interface
Parameters:
- REG_W, 5, register-index width
- ZERO_REG, 31, XZR index; never forwarded, never causes a stall

Ports:
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- id_rn  input  REG_W  first source register of the instruction in ID
- id_rm  input  REG_W  second source register in ID; the decoder has already selected Rt for STUR/CBZ
- id_uses_rn  input  1  ID instruction reads id_rn
- id_uses_rm  input  1  ID instruction reads id_rm
- id_rd  input  REG_W  destination register in ID
- id_reg_write  input  1  ID instruction writes the register file
- id_mem_read  input  1  ID instruction is a load (LDUR)
- flush  input  1  squash the instruction in ID (branch taken)
- forward_a  output  2  EX operand-A mux select
- forward_b  output  2  EX operand-B mux select
- stall  output  1  load-use hazard detected this cycle
- pc_write  output  1  PC register enable (= !stall)
- ifid_write  output  1  IF/ID register enable (= !stall)
- idex_bubble  output  1  zero ID/EX control fields on this edge (= stall | flush)

## Operation
- Shadow stages:
  - ID/EX holds {rn, rm, uses_rn, uses_rm, rd, reg_write, mem_read}.
  - EX/MEM and MEM/WB each hold {rd, reg_write}.
- Bubble value: reg_write=0, mem_read=0, uses_*=0, all indices = ZERO_REG.
- Every rising clk edge:
  - ID/EX <= idex_bubble ? bubble : ID inputs.
  - EX/MEM <= ID/EX.
  - MEM/WB <= EX/MEM.
- Select encoding, matching the operand mux ports a/b/c:
  - 2'b00: register-file value
  - 2'b01: MEM/WB writeback data
  - 2'b10: EX/MEM ALU result
  - 2'b11: never driven
- forward_a is combinational from the shadow registers only:
  - 2'b10 if idex.uses_rn && exmem.reg_write && exmem.rd != ZERO_REG && exmem.rd == idex.rn
  - else 2'b01 if the same conditions hold against memwb
  - else 2'b00
- forward_b: identical logic using rm and uses_rm.
- EX/MEM has priority over MEM/WB, so the youngest producer wins.
- stall (combinational) = !flush && idex.mem_read && idex.rd != ZERO_REG && ((id_uses_rn && id_rn == idex.rd) || (id_uses_rm && id_rm == idex.rd)).
- After a stall edge, the bubble sits in ID/EX and the load moves to EX/MEM. Stall therefore deasserts the next cycle and forward selects 2'b01 once the load reaches MEM/WB.
- Reset:
  - All three shadow stages are set to the bubble value.
  - Outputs after reset: forward_a=forward_b=2'b00, stall=0, pc_write=1, ifid_write=1, idex_bubble=0 (with flush low).

## Timing
- Forward selects: zero latency relative to the shadow registers. They are valid the same cycle the consumer is in EX.
- Producer-to-consumer distance:
  - Distance 1: forward 2'b10.
  - Distance 2: forward 2'b01.
  - Distance 3 or more: 2'b00. The register file writes in the first half-cycle; that is outside this block.
- Load-use costs exactly one stall cycle; stall is never asserted two consecutive cycles for the same load.
- flush and stall in the same cycle: flush wins. stall=0, pc_write=1, ifid_write=1, idex_bubble=1.
- rn == rm == producer rd: both selects take the same code.
- Simultaneous EX/MEM and MEM/WB match: 2'b10.
- Reset asserted mid-stream: shadow stages clear immediately (asynchronously). The outputs go to their reset values in the same cycle, without waiting for a clock edge.

## Test plan
- Reset: rst_n=0 with arbitrary inputs, then release -> forward_a/b=00, stall=0, pc_write=ifid_write=1, and they remain so for 3 idle cycles.
- ALU distance 1/2: ADD X1 (rd=1, rw=1), then SUB reading rn=1 one cycle later -> forward_a=10 while SUB is in EX. Repeat with one NOP between -> forward_a=01.
- Double producer: ADD X2 then ADD X2, consumer reads rm=2 -> forward_b=10, not 01.
- XZR: producer rd=31, rw=1, consumer rn=31 -> forward_a=00. A load to X31 followed by a use -> stall=0.
- Load-use: LDUR X3 (mem_read=1) with the next instruction using rm=3 -> stall=1, pc_write=0, ifid_write=0, idex_bubble=1 for exactly one cycle. The next cycle forward_b=01 when the consumer enters EX.
- Flush priority: load-use condition present with flush=1 -> stall=0, idex_bubble=1, and ID/EX captures the bubble, so the next-cycle forward selects are 00.
